// File: rtl/div23_selftest.sv
// rtl/div23_selftest.sv - sweeps every 16-bit dividend through a constant divider stage and checks each quotient.
module div23_selftest #(
    parameter int DIVISOR = 23,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] x_out,
    input  logic [11:0] q_in,
    output logic [4:0]  r_out,
    output logic        r_valid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_x
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [17:0] DIV18 = 18'(DIVISOR);

    state_t             state_q, state_d;
    logic [15:0]        x_q, x_d;
    logic [LATENCY-1:0] tag_v_q;
    logic [15:0]        tag_x_q [LATENCY];
    logic [4:0]         r_q, r_d;
    logic               rv_q;
    logic [15:0]        err_q, err_d;
    logic [15:0]        first_q, first_d;
    logic               seen_q, seen_d;
    logic               issue;
    logic               restart;
    logic               chk;
    logic               bad;
    logic signed [17:0] rem;

    // Remainder of the oldest tagged dividend against the quotient it produced.
    assign chk = tag_v_q[LATENCY-1];
    assign rem = $signed({2'b00, tag_x_q[LATENCY-1]} - DIV18 * {6'b000000, q_in});
    assign bad = rem[17] || (rem[16:0] > 17'(DIVISOR - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        issue   = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = '0;
                    restart = 1'b1;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (x_q == 16'hFFFF) begin
                    state_d = FLUSH;
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
            FLUSH: begin
                if (!(|tag_v_q)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_d     = chk ? rem[4:0] : 5'd0;
        err_d   = err_q;
        first_d = first_q;
        seen_d  = seen_q;
        if (restart) begin
            err_d   = '0;
            first_d = '0;
            seen_d  = 1'b0;
        end else if (chk && bad) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (!seen_q) begin
                first_d = tag_x_q[LATENCY-1];
            end
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            tag_v_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_x_q[i] <= '0;
            end
            r_q     <= '0;
            rv_q    <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            for (int i = LATENCY - 1; i > 0; i--) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_x_q[i] <= tag_x_q[i-1];
            end
            tag_v_q[0] <= issue;
            tag_x_q[0] <= x_q;
            r_q     <= r_d;
            rv_q    <= chk;
            err_q   <= err_d;
            first_q <= first_d;
            seen_q  <= seen_d;
        end
    end

    assign x_out       = x_q;
    assign r_out       = r_q;
    assign r_valid     = rv_q;
    assign busy        = (state_q == RUN) || (state_q == FLUSH);
    assign done        = (state_q == DONE);
    assign pass        = (state_q == DONE) && (err_q == 16'd0);
    assign err_count   = err_q;
    assign first_err_x = first_q;

endmodule

// File: tb/tb_div23_selftest.sv
// tb/tb_div23_selftest.sv - scoreboard bench for div23_selftest with a behavioural divider model.
module tb_div23_selftest;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x_out;
    logic [11:0] q_in;
    logic [4:0]  r_out;
    logic        r_valid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_err_x;

    typedef struct {
        int         x;
        logic [4:0] r;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   nvalid;
    int   first_v;
    int   last_v;
    int   mode;
    bit   bad_x [65536];

    div23_selftest #(.DIVISOR(23), .LATENCY(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x_out       (x_out),
        .q_in        (q_in),
        .r_out       (r_out),
        .r_valid     (r_valid),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count),
        .first_err_x (first_err_x)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Quotient the modelled divider returns: exact, stuck at zero, or wrong for chosen dividends.
    function automatic int ref_q(input int x);
        if (mode == 1) return 0;
        if (mode == 2 && bad_x[x]) return (x == 23) ? 0 : x / 23 + 1;
        return x / 23;
    endfunction

    function automatic bit ref_err(input int x);
        int rem;
        rem = x - 23 * ref_q(x);
        return (rem < 0) || (rem > 22);
    endfunction

    function automatic logic [4:0] ref_r(input int x);
        logic [31:0] rv;
        rv = 32'(x - 23 * ref_q(x));
        return rv[4:0];
    endfunction

    function automatic void ref_errs(input int upto, output int cnt, output int first);
        cnt   = 0;
        first = 0;
        for (int x = 0; x <= upto; x++) begin
            if (ref_err(x)) begin
                if (cnt == 0) first = x;
                cnt++;
            end
        end
        if (cnt > 65535) cnt = 65535;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Divider stage model: input register plus output register, two edges of latency.
    initial begin
        int h0, h1;
        h0   = 0;
        h1   = 0;
        q_in = '0;
        forever begin
            @(negedge clk);
            q_in = 12'(ref_q(h1));
            h1   = h0;
            h0   = int'(x_out);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (r_valid === 1'b1) begin
                nvalid++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (sbq.size() == 0) begin
                    check("unexpected r_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("r_out x=%0d", e.x), 32'(r_out), 32'(e.r));
                end
            end else begin
                check("r_out while invalid", 32'(r_out), 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " x_out"}, 32'(x_out), 0);
        check({tag, " r_out"}, 32'(r_out), 0);
        check({tag, " r_valid"}, 32'(r_valid), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " pass"}, 32'(pass), 0);
        check({tag, " err_count"}, 32'(err_count), 0);
        check({tag, " first_err_x"}, 32'(first_err_x), 0);
    endtask

    // Called at a negedge: reset lands mid-cycle, outputs must clear before the next edge.
    task automatic reset_mid(input string tag);
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        sbq.delete();
        rst = 1'b0;
        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 0);
        check({tag, " idle x_out"}, 32'(x_out), 0);
    endtask

    // Starts a sweep (E0 is the next rising edge) and follows it to stop_k or to DONE.
    task automatic run_sweep(input int stop_k, input int hold);
        int e0, ecnt, efirst;
        sbq.delete();
        nvalid  = 0;
        first_v = -1;
        last_v  = -1;
        start   = 1'b1;
        @(negedge clk);
        e0 = cyc;
        for (int k = 0; k <= 65539; k++) begin
            if (k > 0) @(negedge clk);
            if (k == hold) start = 1'b0;
            if (k <= 65535) sbq.push_back('{x: k, r: ref_r(k)});
            if (k < 3 || k % 997 == 0 || k >= 65534 || k == stop_k) begin
                check($sformatf("x_out k=%0d", k), 32'(x_out), (k > 65535) ? 65535 : k);
                check($sformatf("busy k=%0d", k), 32'(busy), 32'(k <= 65538));
                check($sformatf("done k=%0d", k), 32'(done), 32'(k == 65539));
            end
            if (k == stop_k) begin
                ref_errs(k - 3, ecnt, efirst);
                check("err_count mid-run", 32'(err_count), ecnt);
                check("first_err_x mid-run", 32'(first_err_x), efirst);
                return;
            end
        end
        ref_errs(65535, ecnt, efirst);
        check("first r_valid latency", first_v - e0, 3);
        check("last r_valid latency", last_v - e0, 65538);
        check("r_valid cycles", nvalid, 65536);
        check("err_count at done", 32'(err_count), ecnt);
        check("first_err_x at done", 32'(first_err_x), efirst);
        check("pass at done", 32'(pass), 32'(ecnt == 0));
        repeat (3) @(negedge clk);
        check("done held", 32'(done), 1);
        check("x_out held", 32'(x_out), 65535);
    endtask

    initial begin
        int stop2;
        n_cmp = 0;
        n_bad = 0;
        mode  = 0;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Quotient stuck at zero, aborted by reset when x_out reaches 1000.
        mode = 1;
        run_sweep(1000, 1);
        reset_mid("abort stuck");

        // Wrong quotient at x=23 plus a few random dividends, aborted at a random point.
        mode = 2;
        stop2 = int'($urandom_range(200, 3000));
        bad_x[23] = 1'b1;
        for (int i = 0; i < 5; i++) bad_x[$urandom_range(0, stop2)] = 1'b1;
        run_sweep(stop2, 1);
        reset_mid("abort faulty");

        // Clean full sweep with start held high well into RUN.
        mode = 0;
        for (int i = 0; i < 65536; i++) bad_x[i] = 1'b0;
        run_sweep(70000, int'($urandom_range(2, 5000)));

        // Start pulse in DONE restarts from zero with cleared counters.
        run_sweep(40, 1);
        check("restart pass", 32'(pass), 0);
        reset_mid("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #950000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
